// File: rtl/uart_rx_word.sv
// 16x-oversampled UART receiver that gathers BYTE frames (low byte first) into one
// DATA_OUT_WIDTH word, flagging framing errors and inter-byte idle timeouts.
module uart_rx_word #(
    parameter int BYTE           = 2,
    parameter int DATA_OUT_WIDTH = 12,
    parameter int UART_WIDTH     = 8,
    parameter int TIMEOUT_BITS   = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      uart_tick,
    input  logic                      Rx,
    output logic [DATA_OUT_WIDTH-1:0] rx_data_out,
    output logic                      rx_done,
    output logic                      rx_err
);

    localparam int IDX_W    = (BYTE > 1) ? $clog2(BYTE) : 1;
    localparam int BIT_W    = (UART_WIDTH > 1) ? $clog2(UART_WIDTH) : 1;
    localparam int TO_TICKS = TIMEOUT_BITS * 16;
    localparam int IDLE_W   = (TO_TICKS > 1) ? $clog2(TO_TICKS) : 1;

    localparam logic [IDLE_W-1:0] TO_LAST  = IDLE_W'((TO_TICKS > 0) ? TO_TICKS - 1 : 0);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(UART_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                    state;
    logic                      rx_p0, rx_s;
    logic                      armed;
    logic [3:0]                tick_cnt;
    logic [BIT_W-1:0]          bit_cnt;
    logic [IDX_W-1:0]          byte_idx;
    logic [IDLE_W-1:0]         idle_cnt;
    logic [UART_WIDTH-1:0]     shreg;
    logic [DATA_OUT_WIDTH-1:0] word;
    logic [DATA_OUT_WIDTH-1:0] word_next;

    // stage p0/s: two-flop synchronizer for the asynchronous line
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= Rx;
            rx_s  <= rx_p0;
        end
    end

    // Word with the current shift register dropped into slot byte_idx; top-byte bits
    // beyond DATA_OUT_WIDTH have no slot and are simply never looked at.
    for (genvar b = 0; b < BYTE; b++) begin : g_slot
        for (genvar i = 0; i < UART_WIDTH; i++) begin : g_bit
            if (b * UART_WIDTH + i < DATA_OUT_WIDTH) begin : g_keep
                assign word_next[b*UART_WIDTH+i] =
                    (byte_idx == IDX_W'(b)) ? shreg[i] : word[b*UART_WIDTH+i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            armed       <= 1'b0;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            byte_idx    <= '0;
            idle_cnt    <= '0;
            rx_data_out <= '0;
            rx_done     <= 1'b0;
            rx_err      <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            rx_err  <= 1'b0;
            if (uart_tick) begin
                case (state)
                    IDLE: begin
                        if (rx_s) armed <= 1'b1;
                        if (TIMEOUT_BITS > 0 && byte_idx != '0) begin
                            if (idle_cnt == TO_LAST) begin
                                rx_err   <= 1'b1;
                                byte_idx <= '0;
                                idle_cnt <= '0;
                            end else begin
                                idle_cnt <= idle_cnt + IDLE_W'(1);
                            end
                        end else begin
                            idle_cnt <= '0;
                        end
                        // a start edge coinciding with a timeout still begins byte 0
                        if (!rx_s && armed) begin
                            state    <= START;
                            tick_cnt <= '0;
                            idle_cnt <= '0;
                        end
                    end
                    START: begin
                        if (tick_cnt == 4'd7) begin
                            if (!rx_s) begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt == 4'd15) begin
                            tick_cnt <= '0;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                state   <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    STOP: begin
                        if (tick_cnt == 4'd15) begin
                            tick_cnt <= '0;
                            state    <= IDLE;
                            if (rx_s) begin
                                if (byte_idx == LAST_IDX) begin
                                    rx_data_out <= word_next;
                                    rx_done     <= 1'b1;
                                    byte_idx    <= '0;
                                end else begin
                                    byte_idx <= byte_idx + IDX_W'(1);
                                end
                            end else begin
                                rx_err   <= 1'b1;
                                byte_idx <= '0;
                                armed    <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Datapath registers carry no reset: every bit is rewritten before it is used.
    always_ff @(posedge clk) begin
        if (uart_tick && state == DATA && tick_cnt == 4'd15)
            shreg[bit_cnt] <= rx_s;
        if (uart_tick && state == STOP && tick_cnt == 4'd15 && rx_s && byte_idx != LAST_IDX)
            word <= word_next;
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed and randomized bench for uart_rx_word: frames are bit-banged onto Rx and
// received words are compared with the words the bench itself chose to send.
module tb_uart_rx_word;

    localparam int DOW = 12;

    logic           clk;
    logic           reset;
    logic           uart_tick;
    logic           Rx;
    logic [DOW-1:0] rx_data_out;
    logic           rx_done;
    logic           rx_err;

    int checks = 0;
    int errors = 0;

    logic [DOW-1:0] done_q[$];
    logic [DOW-1:0] exp_q[$];
    int             done_rd  = 0;
    int             err_cnt  = 0;
    int             err_base = 0;
    int             both_cnt = 0;

    uart_rx_word #(
        .BYTE(2), .DATA_OUT_WIDTH(DOW), .UART_WIDTH(8), .TIMEOUT_BITS(32)
    ) dut (
        .clk(clk), .reset(reset), .uart_tick(uart_tick), .Rx(Rx),
        .rx_data_out(rx_data_out), .rx_done(rx_done), .rx_err(rx_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // one-clock tick every fourth clock
    initial begin
        uart_tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 uart_tick = 1'b1;
            @(posedge clk);
            #1 uart_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_done) done_q.push_back(rx_data_out);
        if (rx_err) err_cnt++;
        if (rx_done && rx_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (uart_tick !== 1'b1);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        Rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            wait_ticks(16);
        end
        Rx = stop_bit;
        wait_ticks(16);
        Rx = 1'b1;
    endtask

    // Reference: a word is its low byte then its top byte; the receiver keeps only
    // the low DOW bits, so junk in the top nibble must vanish.
    task automatic send_word(input logic [11:0] w, input logic [3:0] junk, input int gap);
        logic [15:0] full;
        full = {junk, w};
        exp_q.push_back(full[DOW-1:0]);
        send_frame(full[7:0], 1'b1);
        if (gap > 0) wait_ticks(gap);
        send_frame(full[15:8], 1'b1);
        if (gap > 0) wait_ticks(gap);
    endtask

    task automatic check_words(input string tag, input int exp_errs);
        int          n_exp;
        int          n_got;
        logic [31:0] got;
        n_exp = exp_q.size();
        n_got = done_q.size() - done_rd;
        check({tag, " done count"}, n_got, n_exp);
        for (int k = 0; k < n_exp; k++) begin
            if (done_rd < done_q.size()) begin
                got = 32'(done_q[done_rd]);
                done_rd++;
            end else begin
                got = 32'hDEAD_BEEF;
            end
            check({tag, " word"}, got, 32'(exp_q[k]));
        end
        exp_q.delete();
        done_rd = done_q.size();
        check({tag, " err count"}, err_cnt - err_base, exp_errs);
        err_base = err_cnt;
    endtask

    initial begin
        logic [11:0] w;
        logic [3:0]  junk;
        int          gap;

        reset = 1'b1;
        Rx    = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset data", rx_data_out, 0);
        check("reset done", rx_done, 0);
        check("reset err", rx_err, 0);
        reset = 1'b0;
        wait_ticks(32);

        // basic word
        send_word(12'h5A3, 4'h0, 16);
        check_words("word 5A3", 0);
        wait_ticks(40);
        check("hold 5A3", rx_data_out, 32'h5A3);

        // short low glitch must not start a frame
        Rx = 1'b0;
        wait_ticks(4);
        Rx = 1'b1;
        wait_ticks(32);
        check_words("glitch", 0);
        send_word(12'h3C6, 4'h0, 8);
        check_words("after glitch", 0);

        // framing error on the second byte discards the partial word
        send_frame(8'hA3, 1'b1);
        send_frame(8'h05, 1'b0);
        wait_ticks(32);
        check_words("framing", 1);
        send_word(12'h0FF, 4'h0, 0);
        check_words("after framing", 0);

        // inter-byte idle of 33 bit-times exceeds the 32 bit-time limit
        send_frame(8'h12, 1'b1);
        wait_ticks(33 * 16);
        check_words("timeout", 1);
        send_word(12'hC34, 4'h0, 0);
        check_words("after timeout", 0);

        // back-to-back words with no idle gap at all
        send_word(12'h001, 4'h0, 0);
        send_word(12'hFFF, 4'h0, 0);
        send_word(12'h800, 4'h0, 0);
        check_words("back to back", 0);
        check("hold 800", rx_data_out, 32'h800);

        // reset in the middle of data bit 4 of the second byte
        send_frame(8'h3C, 1'b1);
        Rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            Rx = i[0];
            wait_ticks(16);
        end
        Rx = 1'b1;
        wait_ticks(8);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midreset data", rx_data_out, 0);
        check("midreset done", rx_done, 0);
        check("midreset err", rx_err, 0);
        reset = 1'b0;
        wait_ticks(40);
        check_words("midreset", 0);
        send_word(12'h7E5, 4'h0, 4);
        check_words("after reset", 0);

        // randomized words, gaps and ignored top-byte padding
        for (int k = 0; k < 8; k++) begin
            w    = 12'($urandom_range(0, 4095));
            junk = 4'($urandom_range(0, 15));
            gap  = $urandom_range(0, 40);
            send_word(w, junk, gap);
        end
        wait_ticks(20);
        check_words("random", 0);
        check("done with err", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
